// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, WIDTH iterations.
// Signed DIV/REM support is built only when the DIV_SIGNED_EN macro is defined.

module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_r;
    logic [CW-1:0]    cnt_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic [WIDTH:0]   shift_s;
    logic [WIDTH+1:0] diff_s;
    logic             borrow_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] dvd_in_s;
    logic [WIDTH-1:0] dvs_in_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;
    logic             accept_s;
    logic             unused_diff_s;

    // Trial subtraction of the shifted partial remainder; the top bit is the borrow.
    always_comb begin
        shift_s    = {rem_r, dvd_r[WIDTH-1]};
        diff_s     = {1'b0, shift_s} - {2'b00, dvs_r};
        borrow_s   = diff_s[WIDTH+1];
        if (borrow_s) begin
            rem_next_s = shift_s[WIDTH-1:0];
        end else begin
            rem_next_s = diff_s[WIDTH-1:0];
        end
    end

    // A restored difference is always below the divisor, so bit WIDTH carries no information.
    assign unused_diff_s = diff_s[WIDTH];

    assign accept_s = start & ~flush & ((state_r == IDLE) | (state_r == FIN));

`ifdef DIV_SIGNED_EN
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        negate = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic neg_dvd_s;
    logic neg_dvs_s;
    logic neg_q_r;
    logic neg_r_r;

    // Magnitude conversion on entry and sign restoration on exit.
    always_comb begin
        neg_dvd_s = is_signed & dividend[WIDTH-1];
        neg_dvs_s = is_signed & divisor[WIDTH-1];
        if (neg_dvd_s) begin
            dvd_in_s = negate(dividend);
        end else begin
            dvd_in_s = dividend;
        end
        if (neg_dvs_s) begin
            dvs_in_s = negate(divisor);
        end else begin
            dvs_in_s = divisor;
        end
        if (neg_q_r) begin
            q_fix_s = negate(dvd_r);
        end else begin
            q_fix_s = dvd_r;
        end
        if (neg_r_r) begin
            r_fix_s = negate(rem_r);
        end else begin
            r_fix_s = rem_r;
        end
    end

    // Sign flags: a zero divisor leaves the all-ones quotient uncorrected (reads as -1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (accept_s) begin
            neg_q_r <= (neg_dvd_s ^ neg_dvs_s) & (divisor != {WIDTH{1'b0}});
            neg_r_r <= neg_dvd_s;
        end
    end
`else
    logic unused_sign_s;

    // Unsigned-only build: operands and results pass through untouched.
    always_comb begin
        dvd_in_s = dividend;
        dvs_in_s = divisor;
        q_fix_s  = dvd_r;
        r_fix_s  = rem_r;
    end

    assign unused_sign_s = is_signed;
`endif

    // Divider control and datapath; the dividend register fills with quotient bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            dvd_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            zero_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            div_zero_r  <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
        end else if (flush) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, FIN: begin
                    done_r <= 1'b0;
                    if (start) begin
                        dvd_r   <= dvd_in_s;
                        dvs_r   <= dvs_in_s;
                        rem_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        zero_r  <= (divisor == {WIDTH{1'b0}});
                        busy_r  <= 1'b1;
                        state_r <= CALC;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    if (cnt_r == LAST_CNT) begin
                        quotient_r  <= q_fix_s;
                        remainder_r <= r_fix_s;
                        div_zero_r  <= zero_r;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= FIN;
                    end else begin
                        rem_r <= rem_next_s;
                        dvd_r <= {dvd_r[WIDTH-2:0], ~borrow_s};
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign div_zero  = div_zero_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider (WIDTH=32); expectations
// follow the DIV_SIGNED_EN setting of the build.

module tb_iter_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int tests_run = 0;
    int tests_failed = 0;

    iter_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed), .flush(flush),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .div_zero(div_zero), .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    // Issue one start pulse and count edges until done (bounded at 40 edges).
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        dividend = a; divisor = b; is_signed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
        tests_run++; if (div_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_divzero got %b want 0", div_zero); end
        tests_run++; if (quotient !== 32'd0) begin tests_failed++; $display("FAIL reset_quot got %h want 0", quotient); end
        tests_run++; if (remainder !== 32'd0) begin tests_failed++; $display("FAIL reset_rem got %h want 0", remainder); end
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat, bc;
        do_div(32'd100, 32'd7, 1'b0, lat, bc);
        tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL u100_7_latency got %0d want 33", lat); end
        tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL u100_7_busy_cycles got %0d want 33", bc); end
        tests_run++; if (quotient !== 32'd14) begin tests_failed++; $display("FAIL u100_7_quot got %h want e", quotient); end
        tests_run++; if (remainder !== 32'd2) begin tests_failed++; $display("FAIL u100_7_rem got %h want 2", remainder); end
        tests_run++; if (div_zero !== 1'b0) begin tests_failed++; $display("FAIL u100_7_divzero got %b want 0", div_zero); end
        @(posedge clk); #1;
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL u100_7_done_pulse got %b want 0", done); end
        tests_run++; if (quotient !== 32'd14) begin tests_failed++; $display("FAIL u100_7_hold got %h want e", quotient); end

        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, lat, bc);
        tests_run++; if (quotient !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL umax_1_quot got %h want ffffffff", quotient); end
        tests_run++; if (remainder !== 32'd0) begin tests_failed++; $display("FAIL umax_1_rem got %h want 0", remainder); end

        do_div(32'd5, 32'h10, 1'b0, lat, bc);
        tests_run++; if (quotient !== 32'd0) begin tests_failed++; $display("FAIL u5_16_quot got %h want 0", quotient); end
        tests_run++; if (remainder !== 32'd5) begin tests_failed++; $display("FAIL u5_16_rem got %h want 5", remainder); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        do_div(32'd1234, 32'd0, 1'b0, lat, bc);
        tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL dz_latency got %0d want 33", lat); end
        tests_run++; if (quotient !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL dz_quot got %h want ffffffff", quotient); end
        tests_run++; if (remainder !== 32'd1234) begin tests_failed++; $display("FAIL dz_rem got %h want 4d2", remainder); end
        tests_run++; if (div_zero !== 1'b1) begin tests_failed++; $display("FAIL dz_flag got %b want 1", div_zero); end
        // -5/0 yields quotient -1 and remainder = dividend in either build
        do_div(32'hFFFF_FFFB, 32'd0, 1'b1, lat, bc);
        tests_run++; if (quotient !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL sdz_quot got %h want ffffffff", quotient); end
        tests_run++; if (remainder !== 32'hFFFF_FFFB) begin tests_failed++; $display("FAIL sdz_rem got %h want fffffffb", remainder); end
        tests_run++; if (div_zero !== 1'b1) begin tests_failed++; $display("FAIL sdz_flag got %b want 1", div_zero); end
    endtask

    task automatic test_signed();
        int lat, bc;
        logic [31:0] eq1, er1, eq2, er2, eq3, er3;
`ifdef DIV_SIGNED_EN
        eq1 = 32'hFFFF_FFFD; er1 = 32'hFFFF_FFFF;
        eq2 = 32'hFFFF_FFFD; er2 = 32'd1;
        eq3 = 32'h8000_0000; er3 = 32'd0;
`else
        eq1 = 32'h7FFF_FFFC; er1 = 32'd1;
        eq2 = 32'd0;         er2 = 32'd7;
        eq3 = 32'd0;         er3 = 32'h8000_0000;
`endif
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bc);
        tests_run++; if (quotient !== eq1) begin tests_failed++; $display("FAIL sm7_2_quot got %h want %h", quotient, eq1); end
        tests_run++; if (remainder !== er1) begin tests_failed++; $display("FAIL sm7_2_rem got %h want %h", remainder, er1); end
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, lat, bc);
        tests_run++; if (quotient !== eq2) begin tests_failed++; $display("FAIL s7_m2_quot got %h want %h", quotient, eq2); end
        tests_run++; if (remainder !== er2) begin tests_failed++; $display("FAIL s7_m2_rem got %h want %h", remainder, er2); end
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bc);
        tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL sovf_latency got %0d want 33", lat); end
        tests_run++; if (quotient !== eq3) begin tests_failed++; $display("FAIL sovf_quot got %h want %h", quotient, eq3); end
        tests_run++; if (remainder !== er3) begin tests_failed++; $display("FAIL sovf_rem got %h want %h", remainder, er3); end
        tests_run++; if (div_zero !== 1'b0) begin tests_failed++; $display("FAIL sovf_divzero got %b want 0", div_zero); end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            start = (lat == 10);
            if (lat == 10) begin dividend = 32'd50; divisor = 32'd5; end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL restart_latency got %0d want 33", lat); end
        tests_run++; if (quotient !== 32'd14) begin tests_failed++; $display("FAIL restart_quot got %h want e", quotient); end
        tests_run++; if (remainder !== 32'd2) begin tests_failed++; $display("FAIL restart_rem got %h want 2", remainder); end
    endtask

    task automatic test_flush();
        int lat;
        bit seen;
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            start = (lat == 5);
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL flush_pre_busy got %b want 1", busy); end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL flush_done got %b want 0", done); end
        tests_run++; if (quotient !== 32'd14) begin tests_failed++; $display("FAIL flush_quot got %h want e", quotient); end
        tests_run++; if (remainder !== 32'd2) begin tests_failed++; $display("FAIL flush_rem got %h want 2", remainder); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL flush_no_done got %b want 0", seen); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL areset_busy got %b want 0", busy); end
        tests_run++; if (quotient !== 32'd0) begin tests_failed++; $display("FAIL areset_quot got %h want 0", quotient); end
        tests_run++; if (remainder !== 32'd0) begin tests_failed++; $display("FAIL areset_rem got %h want 0", remainder); end
        tests_run++; if (div_zero !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL areset_flags got %b%b want 00", div_zero, done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_div(32'd100, 32'd7, 1'b0, lat, bc);
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_done got %b want 1", done); end
        do_div(32'd1000, 32'd3, 1'b0, lat, bc);
        tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL b2b_latency got %0d want 33", lat); end
        tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL b2b_busy_cycles got %0d want 33", bc); end
        tests_run++; if (quotient !== 32'd333) begin tests_failed++; $display("FAIL b2b_quot got %h want 14d", quotient); end
        tests_run++; if (remainder !== 32'd1) begin tests_failed++; $display("FAIL b2b_rem got %h want 1", remainder); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_div_zero();
        test_signed();
        test_start_ignored();
        test_flush();
        test_async_reset();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
